instr_fetch_dispatch: RTL

INSTR_FETCH_DISPATCH -- requirements
Module: instr_fetch_dispatch

---
 rtl/nona_isa_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/instr_fetch_dispatch.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/nona_isa_pkg.sv
`default_nettype none
// =============================================================================
// Module   : nona_isa_pkg
// Brief    : Opcode constants, instruction geometry and fetch FSM encoding
//            shared by the instruction fetch/dispatch block.
// Revision : 1.0 - initial release
// =============================================================================
package nona_isa_pkg;

  localparam int INSTR_BYTES   = 3;
  localparam int DEF_NUM_CORES = 9;

  localparam logic [7:0] OPC_NOP = 8'h00;
  localparam logic [7:0] OPC_LDI = 8'h01;
  localparam logic [7:0] OPC_ADD = 8'h05;
  localparam logic [7:0] OPC_JMP = 8'h10;
  localparam logic [7:0] OPC_HLT = 8'h14;

  typedef enum logic [2:0] {
    ST_SEL   = 3'd0,
    ST_RD_OP = 3'd1,
    ST_RD_A  = 3'd2,
    ST_RD_B  = 3'd3,
    ST_CAP   = 3'd4,
    ST_ISSUE = 3'd5
  } ifd_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick over a request vector, searching
//            upward from the entry after i_last and wrapping.
// Revision : 1.0 - initial release
// =============================================================================
module rr_arbiter #(
  parameter int NUM_CORES = 9
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [3:0]           i_last,
  output logic [3:0]           o_grant,
  output logic                 o_valid
);

  int w_dist;
  int w_best;

  // Distance 0 is the entry immediately after i_last; the nearest requester wins.
  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    w_best  = NUM_CORES;
    w_dist  = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_dist = (i + 2 * NUM_CORES - 1 - int'(i_last)) % NUM_CORES;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_dispatch.sv
`default_nettype none
// =============================================================================
// Module   : instr_fetch_dispatch
// Brief    : Serialized 3-byte instruction fetch for NUM_CORES cores with
//            round-robin core selection and execute-stage PC redirects.
//            Optional HLT halting enabled by defining IFD_HALT_DETECT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module instr_fetch_dispatch
  import nona_isa_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int PC_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_rd,
  output logic [PC_W-1:0]      mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [3:0]           core_id,
  output logic [7:0]           instruction,
  output logic [7:0]           operand1,
  output logic [7:0]           operand2,
  input  logic                 redirect_valid,
  input  logic [3:0]           redirect_core,
  input  logic [PC_W-1:0]      redirect_pc,
  output logic [NUM_CORES-1:0] halt_mask
);

  ifd_state_e           r_state;
  logic [3:0]           r_core;
  logic [3:0]           r_last;
  logic [7:0]           r_opc;
  logic [7:0]           r_op1;
  logic [7:0]           r_op2;
  logic [PC_W-1:0]      r_pc [NUM_CORES];

  logic [PC_W-1:0]      w_pc;
  logic                 w_hs;
  logic                 w_redir;
  logic                 w_abort;
  logic                 w_hlt_hs;
  logic                 w_gnt_valid;
  logic [3:0]           w_gnt;
  logic [NUM_CORES-1:0] w_req;

  assign w_hs    = (r_state == ST_ISSUE) && issue_ready;
  assign w_redir = redirect_valid && (int'(redirect_core) < NUM_CORES);
  assign w_abort = w_redir && (redirect_core == r_core) && (r_state != ST_SEL);
  assign w_req   = ~halt_mask;

  always_comb begin
    w_pc = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (r_core == 4'(c)) w_pc = r_pc[c];
    end
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (r_state)
      ST_RD_OP: begin mem_rd = 1'b1; mem_addr = w_pc;              end
      ST_RD_A:  begin mem_rd = 1'b1; mem_addr = w_pc + PC_W'(1);   end
      ST_RD_B:  begin mem_rd = 1'b1; mem_addr = w_pc + PC_W'(2);   end
      default:  ;
    endcase
  end

  assign issue_valid = (r_state == ST_ISSUE);
  assign core_id     = r_core;
  assign instruction = r_opc;
  assign operand1    = r_op1;
  assign operand2    = r_op2;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_arb (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_gnt),
    .o_valid (w_gnt_valid)
  );

`ifdef IFD_HALT_DETECT_EN
  logic [NUM_CORES-1:0] r_halt;

  assign w_hlt_hs  = w_hs && (r_opc == OPC_HLT);
  assign halt_mask = r_halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_halt <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (w_redir && (redirect_core == 4'(c)))   r_halt[c] <= 1'b0;
        else if (w_hlt_hs && (r_core == 4'(c)))    r_halt[c] <= 1'b1;
      end
    end
  end
`else
  assign w_hlt_hs  = 1'b0;
  assign halt_mask = '0;
`endif

  // Byte captures trail each read strobe by one state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SEL;
      r_core  <= '0;
      r_last  <= 4'(NUM_CORES - 1);
      r_opc   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
    end else begin
      case (r_state)
        ST_SEL: begin
          if (w_gnt_valid) begin
            r_core  <= w_gnt;
            r_state <= ST_RD_OP;
          end
        end
        ST_RD_OP: r_state <= ST_RD_A;
        ST_RD_A:  begin r_opc <= mem_rdata; r_state <= ST_RD_B;  end
        ST_RD_B:  begin r_op1 <= mem_rdata; r_state <= ST_CAP;   end
        ST_CAP:   begin r_op2 <= mem_rdata; r_state <= ST_ISSUE; end
        ST_ISSUE: begin
          if (issue_ready) begin
            r_last  <= r_core;
            r_state <= ST_SEL;
          end
        end
        default:  r_state <= ST_SEL;
      endcase
      if (w_abort) r_state <= ST_SEL;
    end
  end

  // A redirect overrides the post-issue advance for the same core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CORES; c++) r_pc[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (w_redir && (redirect_core == 4'(c)))
          r_pc[c] <= redirect_pc;
        else if (w_hs && !w_hlt_hs && (r_core == 4'(c)))
          r_pc[c] <= r_pc[c] + PC_W'(INSTR_BYTES);
      end
    end
  end

endmodule
`default_nettype wire
